// File: rtl/dram_write_combiner.sv
// Single-entry write combiner: merges same-line beats by lane mask and forwards
// a line to DRAM when full, displaced, timed out or flushed by block completion.
module dram_write_combiner #(
    parameter int unsigned GBW   = 32,
    parameter int unsigned DBW   = 32,
    parameter int unsigned CSIZE = 8,
    parameter int unsigned TOUT  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       src_rdy,
    output logic                       src_ack,
    input  logic [GBW-1:0]             i_dramwa,
    input  logic [CSIZE-1:0][DBW-1:0]  i_dramwd,
    input  logic [CSIZE-1:0]           i_dramw_mask,
    input  logic                       blkdone_dval,
    output logic                       dst_rdy,
    input  logic                       dst_ack,
    output logic [GBW-1:0]             o_dramwa,
    output logic [CSIZE-1:0][DBW-1:0]  o_dramwd,
    output logic [CSIZE-1:0]           o_dramw_mask,
    output logic                       o_idle
);

    localparam int unsigned TW = $clog2(TOUT);
    localparam logic [TW-1:0] TMAX = TW'(TOUT - 1);

    logic                      h_valid;
    logic [GBW-1:0]            h_addr;
    logic [CSIZE-1:0][DBW-1:0] h_data;
    logic [CSIZE-1:0]          h_mask;
    logic [TW-1:0]             h_timer;
    logic                      flush_pend;

    logic                      out_free;
    logic                      match;
    logic                      stale;
    logic                      evict;
    logic                      take;
    logic                      merge;
    logic                      load;
    logic [CSIZE-1:0][DBW-1:0] merged_data;

    assign out_free = !dst_rdy || dst_ack;
    assign match    = h_valid && (i_dramwa == h_addr);
    assign stale    = (&h_mask) || (h_timer == TMAX) || flush_pend;
    assign evict    = h_valid && (stale || (src_rdy && !match)) && out_free;
    assign take     = !i_rst && src_rdy && !flush_pend
                      && (!h_valid || (match && !stale) || out_free);
    assign src_ack  = take;

    // Zero-mask beats are acknowledged but neither merge nor load.
    assign merge = take && (|i_dramw_mask) && match && !stale;
    assign load  = take && (|i_dramw_mask) && !(match && !stale);

    assign o_idle = !h_valid && !dst_rdy && !flush_pend;

    always_comb begin
        merged_data = h_data;
        for (int unsigned k = 0; k < CSIZE; k++) begin
            if (i_dramw_mask[k]) begin
                merged_data[k] = i_dramwd[k];
            end
        end
    end

    // A load into a valid entry coincides with evict, which the output
    // register picks up; the hold entry just takes the new beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_valid <= 1'b0;
            h_addr  <= '0;
            h_data  <= '0;
            h_mask  <= '0;
            h_timer <= '0;
        end else if (load) begin
            h_valid <= 1'b1;
            h_addr  <= i_dramwa;
            h_data  <= i_dramwd;
            h_mask  <= i_dramw_mask;
            h_timer <= '0;
        end else if (merge) begin
            h_data  <= merged_data;
            h_mask  <= h_mask | i_dramw_mask;
            h_timer <= '0;
        end else if (evict) begin
            h_valid <= 1'b0;
            h_mask  <= '0;
            h_timer <= '0;
        end else if (h_valid && (h_timer != TMAX)) begin
            h_timer <= h_timer + TW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dst_rdy      <= 1'b0;
            o_dramwa     <= '0;
            o_dramwd     <= '0;
            o_dramw_mask <= '0;
        end else if (evict) begin
            dst_rdy      <= 1'b1;
            o_dramwa     <= h_addr;
            o_dramwd     <= h_data;
            o_dramw_mask <= h_mask;
        end else if (dst_ack) begin
            dst_rdy      <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            flush_pend <= 1'b0;
        end else if (flush_pend) begin
            if (evict || !h_valid) begin
                flush_pend <= 1'b0;
            end
        end else if (blkdone_dval) begin
            flush_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_write_combiner.sv
// Bench for dram_write_combiner: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_dram_write_combiner;

    localparam int unsigned GBW   = 16;
    localparam int unsigned DBW   = 8;
    localparam int unsigned CSIZE = 4;
    localparam int unsigned TOUT  = 16;

    logic                      i_clk = 1'b0;
    logic                      i_rst = 1'b1;
    logic                      src_rdy = 1'b0;
    logic                      src_ack;
    logic [GBW-1:0]            i_dramwa = '0;
    logic [CSIZE-1:0][DBW-1:0] i_dramwd = '0;
    logic [CSIZE-1:0]          i_dramw_mask = '0;
    logic                      blkdone_dval = 1'b0;
    logic                      dst_rdy;
    logic                      dst_ack = 1'b0;
    logic [GBW-1:0]            o_dramwa;
    logic [CSIZE-1:0][DBW-1:0] o_dramwd;
    logic [CSIZE-1:0]          o_dramw_mask;
    logic                      o_idle;

    int vectors = 0;
    int miscompares = 0;
    bit beat_taken = 1'b0;

    dram_write_combiner #(
        .GBW  (GBW),
        .DBW  (DBW),
        .CSIZE(CSIZE),
        .TOUT (TOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .src_rdy     (src_rdy),
        .src_ack     (src_ack),
        .i_dramwa    (i_dramwa),
        .i_dramwd    (i_dramwd),
        .i_dramw_mask(i_dramw_mask),
        .blkdone_dval(blkdone_dval),
        .dst_rdy     (dst_rdy),
        .dst_ack     (dst_ack),
        .o_dramwa    (o_dramwa),
        .o_dramwd    (o_dramwd),
        .o_dramw_mask(o_dramw_mask),
        .o_idle      (o_idle)
    );

    always #5 i_clk = ~i_clk;

    // Model state: the pending line, its idle age, the outgoing line, flush flag.
    typedef struct packed {
        logic                      hv;
        logic [GBW-1:0]            haddr;
        logic [CSIZE-1:0][DBW-1:0] hdata;
        logic [CSIZE-1:0]          hmask;
        logic [31:0]               age;
        logic                      fp;
        logic                      ov;
        logic [GBW-1:0]            oaddr;
        logic [CSIZE-1:0][DBW-1:0] odata;
        logic [CSIZE-1:0]          omask;
    } model_t;

    model_t cur = '0;
    model_t nxt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CSIZE*DBW-1:0] lanes(input logic [CSIZE-1:0][DBW-1:0] d,
                                                   input logic [CSIZE-1:0] m);
        logic [CSIZE*DBW-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < CSIZE; k++) begin
            if (m[k]) r[k*DBW +: DBW] = d[k];
        end
        return r;
    endfunction

    always @(negedge i_clk) begin : cmp
        logic free, same, old, flushout, ack;
        if (i_rst) begin
            check("rst_dst_rdy", 64'(dst_rdy), 64'd0);
            check("rst_src_ack", 64'(src_ack), 64'd0);
            check("rst_o_idle", 64'(o_idle), 64'd1);
            check("rst_o_dramwa", 64'(o_dramwa), 64'd0);
            check("rst_o_dramwd", 64'(o_dramwd), 64'd0);
            check("rst_o_dramw_mask", 64'(o_dramw_mask), 64'd0);
            nxt = '0;
            beat_taken = 1'b0;
        end else begin
            free     = !cur.ov || dst_ack;
            same     = cur.hv && (i_dramwa == cur.haddr);
            old      = (cur.hmask == '1) || (cur.age == TOUT - 1) || cur.fp;
            flushout = cur.hv && (old || (src_rdy && !same)) && free;
            ack      = src_rdy && !cur.fp && (!cur.hv || (same && !old) || free);

            check("src_ack", 64'(src_ack), 64'(ack));
            check("dst_rdy", 64'(dst_rdy), 64'(cur.ov));
            check("o_idle", 64'(o_idle), 64'(!cur.hv && !cur.ov && !cur.fp));
            if (cur.ov) begin
                check("o_dramwa", 64'(o_dramwa), 64'(cur.oaddr));
                check("o_dramw_mask", 64'(o_dramw_mask), 64'(cur.omask));
                check("o_dramwd", 64'(lanes(o_dramwd, cur.omask)), 64'(lanes(cur.odata, cur.omask)));
            end
            beat_taken = src_rdy && ack;

            nxt = cur;
            if (cur.ov && dst_ack) nxt.ov = 1'b0;
            if (flushout) begin
                nxt.ov    = 1'b1;
                nxt.oaddr = cur.haddr;
                nxt.odata = cur.hdata;
                nxt.omask = cur.hmask;
                nxt.hv    = 1'b0;
                nxt.hmask = '0;
                nxt.age   = 0;
            end else if (cur.hv && cur.age < TOUT - 1) begin
                nxt.age = cur.age + 1;
            end
            if (ack && i_dramw_mask != '0) begin
                if (same && !old) begin
                    for (int unsigned k = 0; k < CSIZE; k++)
                        if (i_dramw_mask[k]) nxt.hdata[k] = i_dramwd[k];
                    nxt.hmask = cur.hmask | i_dramw_mask;
                end else begin
                    nxt.hv    = 1'b1;
                    nxt.haddr = i_dramwa;
                    nxt.hdata = i_dramwd;
                    nxt.hmask = i_dramw_mask;
                end
                nxt.age = 0;
            end
            if (cur.fp) begin
                if (flushout || !cur.hv) nxt.fp = 1'b0;
            end else if (blkdone_dval) begin
                nxt.fp = 1'b1;
            end
        end
    end

    always @(posedge i_clk) cur <= nxt;

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [GBW-1:0] a, input logic [CSIZE-1:0] m, input logic [31:0] d);
        int n = 0;
        src_rdy = 1'b1;
        i_dramwa = a;
        i_dramw_mask = m;
        i_dramwd = d;
        forever begin
            @(negedge i_clk);
            if (src_ack) break;
            n++;
            if (n > 64) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: addr 0x%0h never acked, required ack within 64 cycles", a);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        src_rdy = 1'b0;
    endtask

    task automatic drain();
        @(posedge i_clk);
        #1 dst_ack = 1'b1;
        @(posedge i_clk);
        #1 dst_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        check("async_rst_dst_rdy", 64'(dst_rdy), 64'd0);
        check("async_rst_mask", 64'(o_dramw_mask), 64'd0);
        check("async_rst_idle", 64'(o_idle), 64'd1);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Merge two partial beats, then let the line time out.
        send(16'h0100, 4'b0001, 32'h0000_0011);
        send(16'h0100, 4'b0100, 32'h0033_0000);
        repeat (15) @(posedge i_clk);
        @(negedge i_clk);
        check("t1_before_timeout", 64'(dst_rdy), 64'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        check("t1_dst_rdy", 64'(dst_rdy), 64'd1);
        check("t1_addr", 64'(o_dramwa), 64'h0100);
        check("t1_mask", 64'(o_dramw_mask), 64'b0101);
        check("t1_data", 64'(o_dramwd & 32'h00FF_00FF), 64'h0033_0011);
        drain();

        // Four single-lane beats complete a line.
        send(16'h0200, 4'b0001, 32'h0000_00a1);
        send(16'h0200, 4'b0010, 32'h0000_b200);
        send(16'h0200, 4'b0100, 32'h00c3_0000);
        send(16'h0200, 4'b1000, 32'hd400_0000);
        @(negedge i_clk);
        check("t2_one_cycle", 64'(dst_rdy), 64'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        check("t2_dst_rdy", 64'(dst_rdy), 64'd1);
        check("t2_addr", 64'(o_dramwa), 64'h0200);
        check("t2_mask", 64'(o_dramw_mask), 64'b1111);
        check("t2_data", 64'(o_dramwd), 64'hd4c3_b2a1);
        drain();

        // Address change evicts the held line.
        send(16'h0300, 4'b1100, 32'h5566_0000);
        send(16'h0304, 4'b0011, 32'h0000_7788);
        @(negedge i_clk);
        check("t3_dst_rdy", 64'(dst_rdy), 64'd1);
        check("t3_addr", 64'(o_dramwa), 64'h0300);
        check("t3_mask", 64'(o_dramw_mask), 64'b1100);
        check("t3_data", 64'(o_dramwd & 32'hFFFF_0000), 64'h5566_0000);
        check("t3_held", 64'(o_idle), 64'd0);

        // Backpressure: merge still acked, mismatch waits for dst_ack.
        @(posedge i_clk);
        #1;
        src_rdy = 1'b1;
        i_dramwa = 16'h0304;
        i_dramw_mask = 4'b0100;
        i_dramwd = 32'h0099_0000;
        @(negedge i_clk);
        check("t4_merge_ack", 64'(src_ack), 64'd1);
        @(posedge i_clk);
        #1;
        i_dramwa = 16'h0308;
        i_dramw_mask = 4'b0001;
        i_dramwd = 32'h0000_00ee;
        repeat (3) begin
            @(negedge i_clk);
            check("t4_mismatch_blocked", 64'(src_ack), 64'd0);
            @(posedge i_clk);
            #1;
        end
        dst_ack = 1'b1;
        @(negedge i_clk);
        check("t4_mismatch_ack", 64'(src_ack), 64'd1);
        @(posedge i_clk);
        #1;
        src_rdy = 1'b0;
        dst_ack = 1'b0;
        @(negedge i_clk);
        check("t4_addr", 64'(o_dramwa), 64'h0304);
        check("t4_mask", 64'(o_dramw_mask), 64'b0111);
        check("t4_data", 64'(o_dramwd & 32'h00FF_FFFF), 64'h0099_7788);
        drain();
        do_reset();

        // Block-done flush, with a zero-mask beat waiting behind it.
        send(16'h0400, 4'b0010, 32'h0000_4400);
        blkdone_dval = 1'b1;
        @(posedge i_clk);
        #1;
        blkdone_dval = 1'b0;
        src_rdy = 1'b1;
        i_dramwa = 16'h0500;
        i_dramw_mask = 4'b0000;
        i_dramwd = 32'hdead_beef;
        @(negedge i_clk);
        check("t5_flush_blocks", 64'(src_ack), 64'd0);
        check("t5_not_yet", 64'(dst_rdy), 64'd0);
        @(posedge i_clk);
        #1 dst_ack = 1'b1;
        @(negedge i_clk);
        check("t5_dst_rdy", 64'(dst_rdy), 64'd1);
        check("t5_addr", 64'(o_dramwa), 64'h0400);
        check("t5_mask", 64'(o_dramw_mask), 64'b0010);
        check("t5_data", 64'(o_dramwd & 32'h0000_FF00), 64'h0000_4400);
        check("t5_zero_mask_ack", 64'(src_ack), 64'd1);
        @(posedge i_clk);
        #1;
        src_rdy = 1'b0;
        dst_ack = 1'b0;
        @(negedge i_clk);
        check("t5_idle", 64'(o_idle), 64'd1);
        check("t5_zero_mask_no_out", 64'(dst_rdy), 64'd0);
        @(posedge i_clk);
        #1;

        // Reset with an outgoing line and a held line.
        send(16'h0600, 4'b1111, 32'h1234_5678);
        send(16'h0700, 4'b0001, 32'h0000_00aa);
        @(negedge i_clk);
        check("t6_dst_rdy", 64'(dst_rdy), 64'd1);
        check("t6_addr", 64'(o_dramwa), 64'h0600);
        check("t6_busy", 64'(o_idle), 64'd0);
        do_reset();
        repeat (TOUT + 4) @(posedge i_clk);
        @(negedge i_clk);
        check("t6_discarded", 64'(dst_rdy), 64'd0);
        check("t6_idle", 64'(o_idle), 64'd1);
        @(posedge i_clk);
        #1;

        // Random traffic over three nearby lines with periodic lulls.
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            if (!src_rdy || beat_taken) begin
                src_rdy = (((c / 300) % 4) != 3) && ($urandom_range(0, 3) != 0);
                i_dramwa = 16'h0040 + 16'(4 * $urandom_range(0, 2));
                i_dramw_mask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
                i_dramwd = $urandom;
            end
            dst_ack = ($urandom_range(0, 9) < 7);
            blkdone_dval = ($urandom_range(0, 39) == 0);
            @(posedge i_clk);
            #1;
        end
        src_rdy = 1'b0;
        blkdone_dval = 1'b0;
        dst_ack = 1'b1;
        repeat (TOUT + 8) @(posedge i_clk);
        @(negedge i_clk);
        check("final_idle", 64'(o_idle), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
